rf_fifo_ctl_32_32: RTL and testbench

RF_FIFO_CTL_32_32 -- requirements
Module: rf_fifo_ctl_32_32

---
 rtl/rf_fifo_ctl_32_32_if.sv | 24 ++
 rtl/rf_fifo_ctl_32_32.sv | 137 +++++++++++++
 tb/tb_rf_fifo_ctl_32_32.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_fifo_ctl_32_32_if.sv
// Producer/consumer handshake bundle for rf_fifo_ctl_32_32.
//   push_valid/push_data/push_ready : producer side, write into the FIFO
//   pop_valid/pop_data/pop_ready    : consumer side, head of the queue
// master: the producer/consumer environment; slave: the FIFO controller.
interface rf_fifo_ctl_32_32_if;
    localparam int unsigned DATA_W = 32;

    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/rf_fifo_ctl_32_32.sv
// FIFO controller, 32 x 32 bits, storing data in an external 1R1W register
// file with 1-cycle synchronous read, plus a 2-entry output buffer
// (head + skid) so one word can pop per cycle despite the read latency.
// Ports:
//   rf_clock, rf_reset      : clock, async active-high reset
//   flush                   : synchronous clear of all contents
//   bus (slave)             : push/pop handshake
//   level                   : entries held (RAM + buffer + read in flight), 0..34
//   rf_rd_addr_0/rf_rd_data_0 : register file read port
//   rf_wr_enable/addr/data  : register file write port
module rf_fifo_ctl_32_32 (
    input  logic                  rf_clock,
    input  logic                  rf_reset,
    input  logic                  flush,
    rf_fifo_ctl_32_32_if.slave    bus,
    output logic [5:0]            level,
    output logic [4:0]            rf_rd_addr_0,
    input  logic [31:0]           rf_rd_data_0,
    output logic                  rf_wr_enable,
    output logic [4:0]            rf_wr_addr,
    output logic [31:0]           rf_wr_data
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DEPTH  = 32;

    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]  ram_count, ram_count_n;
    logic              rd_pending, rd_pending_n;
    logic              head_valid, head_valid_n;
    logic [DATA_W-1:0] head_data, head_data_n;
    logic              skid_valid, skid_valid_n;
    logic [DATA_W-1:0] skid_data, skid_data_n;
    logic [CNT_W-1:0]  level_q, level_n;

    logic              push_ok;
    logic              push_fire;
    logic              pop_fire;
    logic              rd_issue;
    logic [1:0]        buf_occ;

    // Handshake decode; flush masks every transfer in its cycle.
    always_comb begin
        push_ok   = (ram_count != CNT_W'(DEPTH)) && !flush;
        push_fire = bus.push_valid && push_ok;
        pop_fire  = head_valid && bus.pop_ready && !flush;
        // Buffer slots still committed after this cycle's pop; never exceeds 2.
        buf_occ   = 2'(head_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(pop_fire);
        rd_issue  = (ram_count != '0) && (buf_occ < 2'd2) && !flush;
    end

    assign bus.push_ready = push_ok;
    assign bus.pop_valid  = head_valid;
    assign bus.pop_data   = head_data;
    assign rf_wr_enable   = push_fire;
    assign rf_wr_addr     = wr_ptr;
    assign rf_wr_data     = bus.push_data;
    assign rf_rd_addr_0   = rd_ptr;
    assign level          = level_q;

    // Next-state: pointers, RAM occupancy and output buffer.
    always_comb begin
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        ram_count_n  = ram_count;
        rd_pending_n = rd_pending;
        head_valid_n = head_valid;
        head_data_n  = head_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;

        if (flush) begin
            wr_ptr_n     = '0;
            rd_ptr_n     = '0;
            ram_count_n  = '0;
            rd_pending_n = 1'b0;
            head_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else begin
            wr_ptr_n     = wr_ptr + ADDR_W'(push_fire);
            rd_ptr_n     = rd_ptr + ADDR_W'(rd_issue);
            ram_count_n  = ram_count + CNT_W'(push_fire) - CNT_W'(rd_issue);
            rd_pending_n = rd_issue;

            // Pop first: head refills from skid when it holds a word.
            if (pop_fire) begin
                if (skid_valid) begin
                    head_data_n  = skid_data;
                    skid_valid_n = 1'b0;
                end else begin
                    head_valid_n = 1'b0;
                end
            end

            // Landing read data fills head if free, otherwise the skid.
            if (rd_pending) begin
                if (!head_valid_n) begin
                    head_valid_n = 1'b1;
                    head_data_n  = rf_rd_data_0;
                end else begin
                    skid_valid_n = 1'b1;
                    skid_data_n  = rf_rd_data_0;
                end
            end
        end

        level_n = ram_count_n + CNT_W'(head_valid_n) + CNT_W'(skid_valid_n)
                + CNT_W'(rd_pending_n);
    end

    // State register.
    always_ff @(posedge rf_clock or posedge rf_reset) begin
        if (rf_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            level_q    <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            ram_count  <= ram_count_n;
            rd_pending <= rd_pending_n;
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            level_q    <= level_n;
        end
    end
endmodule

// File: tb/tb_rf_fifo_ctl_32_32.sv
// Scoreboard bench for rf_fifo_ctl_32_32 with a behavioural 1R1W register file.
module tb_rf_fifo_ctl_32_32;
    logic        rf_clock;
    logic        rf_reset;
    logic        flush;
    logic [5:0]  level;
    logic [4:0]  rf_rd_addr_0;
    logic [31:0] rf_rd_data_0;
    logic        rf_wr_enable;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    rf_fifo_ctl_32_32_if bus ();

    rf_fifo_ctl_32_32 dut (
        .rf_clock     (rf_clock),
        .rf_reset     (rf_reset),
        .flush        (flush),
        .bus          (bus),
        .level        (level),
        .rf_rd_addr_0 (rf_rd_addr_0),
        .rf_rd_data_0 (rf_rd_data_0),
        .rf_wr_enable (rf_wr_enable),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data)
    );

    // Register file model: synchronous write, 1-cycle synchronous read.
    logic [31:0] rf_mem [32];
    always @(posedge rf_clock) begin
        if (rf_wr_enable) rf_mem[rf_wr_addr] <= rf_wr_data;
        rf_rd_data_0 <= rf_mem[rf_rd_addr_0];
    end

    initial rf_clock = 1'b0;
    always #5 rf_clock = ~rf_clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int model_level = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples handshakes just before the rising edge they take effect on.
    always begin
        @(negedge rf_clock);
        #2;
        if (rf_reset) begin
            exp_q.delete();
            model_level = 0;
        end else begin
            check("level", 32'(level), 32'(model_level));
            if (flush) begin
                exp_q.delete();
                model_level = 0;
            end else begin
                if (bus.push_valid && bus.push_ready) begin
                    exp_q.push_back(bus.push_data);
                    model_level++;
                end
                if (bus.pop_valid && bus.pop_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got 0x%08h expected no pop", bus.pop_data);
                    end else begin
                        check("pop_data", bus.pop_data, exp_q.pop_front());
                    end
                    model_level--;
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] d);
        int n;
        n = 0;
        @(negedge rf_clock);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        #1;
        while (!bus.push_ready && n < 60) begin
            @(negedge rf_clock);
            #1;
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got push_ready=0 expected 1 within 60 cycles");
        end
        @(posedge rf_clock);
        #1;
        bus.push_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rf_reset       = 1'b1;
        flush          = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);
        repeat (3) @(negedge rf_clock);
        rf_reset = 1'b0;

        // Single word latency: pop_valid visible three cycles after the push.
        bus.pop_ready = 1'b1;
        @(negedge rf_clock);
        bus.push_valid = 1'b1;
        bus.push_data  = 32'h1111_1111;
        for (int k = 0; k < 4; k++) begin
            @(posedge rf_clock);
            #1;
            if (k == 0) bus.push_valid = 1'b0;
            if (k < 3) check($sformatf("lat_pop_valid_%0d", k), 32'(bus.pop_valid), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) check("lat_pop_data", bus.pop_data, 32'h1111_1111);
            if (k == 3) check("lat_level_end", 32'(level), 32'd0);
        end

        // Fill to 34 with no pops, then drain in order.
        bus.pop_ready = 1'b0;
        repeat (2) @(negedge rf_clock);
        for (int i = 0; i < 34; i++) push_word(32'(i));
        check("full_push_ready", 32'(bus.push_ready), 32'd0);
        check("full_level", 32'(level), 32'd34);
        @(negedge rf_clock);
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hDEAD_BEEF;
        bus.pop_ready  = 1'b1;
        #1;
        check("full_blocks_push", 32'(bus.push_ready), 32'd0);
        @(posedge rf_clock);
        #1;
        bus.push_valid = 1'b0;
        repeat (45) @(negedge rf_clock);
        #3;
        check("drain_level", 32'(level), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        // Sustained streaming: one pop per cycle after the startup latency.
        for (int i = 0; i < 100; i++) begin
            @(negedge rf_clock);
            bus.push_valid = 1'b1;
            bus.push_data  = 32'h1000_0000 + 32'(i);
            #1;
            check("stream_push_ready", 32'(bus.push_ready), 32'd1);
            if (i >= 3) check("stream_pop_valid", 32'(bus.pop_valid), 32'd1);
        end
        @(posedge rf_clock);
        #1;
        bus.push_valid = 1'b0;
        repeat (10) @(negedge rf_clock);
        #3;
        check("stream_queue", 32'(exp_q.size()), 32'd0);

        // Flush with simultaneous push and pop.
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(32'h3000_0000 + 32'(i));
        @(negedge rf_clock);
        flush          = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hBAD0_BAD0;
        bus.pop_ready  = 1'b1;
        #1;
        check("flush_wr_enable", 32'(rf_wr_enable), 32'd0);
        check("flush_push_ready", 32'(bus.push_ready), 32'd0);
        @(posedge rf_clock);
        #1;
        check("flush_level", 32'(level), 32'd0);
        check("flush_pop_valid", 32'(bus.pop_valid), 32'd0);
        flush          = 1'b0;
        bus.push_valid = 1'b0;
        repeat (3) @(negedge rf_clock);
        #1;
        check("flush_no_stale", 32'(bus.pop_valid), 32'd0);

        // Asynchronous reset in the middle of a stream with a read in flight.
        for (int i = 0; i < 8; i++) begin
            @(negedge rf_clock);
            bus.push_valid = 1'b1;
            bus.push_data  = 32'h2000_0000 + 32'(i);
        end
        @(posedge rf_clock);
        #3;
        rf_reset = 1'b1;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_pop_valid", 32'(bus.pop_valid), 32'd0);
        check("arst_push_ready", 32'(bus.push_ready), 32'd1);
        check("arst_wr_enable", 32'(rf_wr_enable), 32'd1);
        @(negedge rf_clock);
        bus.push_valid = 1'b0;
        @(negedge rf_clock);
        rf_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge rf_clock);
            #1;
            check("arst_no_spurious", 32'(bus.pop_valid), 32'd0);
        end
        bus.pop_ready = 1'b0;
        push_word(32'hA5A5_A5A5);
        n = 0;
        while (!bus.pop_valid && n < 20) begin
            @(negedge rf_clock);
            #1;
            n++;
        end
        check("arst_first_word", bus.pop_data, 32'hA5A5_A5A5);
        bus.pop_ready = 1'b1;
        repeat (3) @(negedge rf_clock);

        // Random push/pop traffic.
        for (int c = 0; c < 10000; c++) begin
            @(negedge rf_clock);
            bus.push_valid = 1'($urandom_range(0, 1));
            bus.push_data  = $urandom;
            bus.pop_ready  = 1'($urandom_range(0, 1));
        end
        @(negedge rf_clock);
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        repeat (50) @(negedge rf_clock);
        #3;
        check("rand_queue", 32'(exp_q.size()), 32'd0);
        check("rand_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
